// File: rtl/accumulator_unit_pkg.sv
// ---------------------------------------------------------------------------
// accumulator_unit_pkg
//   Shared definitions for the basic-computer accumulator datapath.
//   - Default widths for AC/DR (AC_W_DEFAULT) and INPR (IN_W_DEFAULT).
//   - One-hot ALU select encoding (SEL_AND .. SEL_INPT). The bit order
//     matches the order in which accumulator_unit packs its select strobes.
//   - alu_eval(): computes the next {E, AC} for one select. It works on
//     AC_MAX-wide vectors, and the real widths come in as constant
//     arguments, so one function serves any AC_W/IN_W up to AC_MAX.
// ---------------------------------------------------------------------------
package accumulator_unit_pkg;

    localparam int unsigned AC_W_DEFAULT = 16;
    localparam int unsigned IN_W_DEFAULT = 8;

    // Widest accumulator alu_eval can handle. The real width must be
    // strictly smaller than this.
    localparam int unsigned AC_MAX = 64;

    localparam int unsigned SEL_W = 7;
    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_NONE = 7'b000_0000;
    localparam sel_t SEL_AND  = 7'b000_0001;
    localparam sel_t SEL_ADD  = 7'b000_0010;
    localparam sel_t SEL_DR   = 7'b000_0100;
    localparam sel_t SEL_SHL  = 7'b000_1000;
    localparam sel_t SEL_SHR  = 7'b001_0000;
    localparam sel_t SEL_COM  = 7'b010_0000;
    localparam sel_t SEL_INPT = 7'b100_0000;

    typedef struct packed {
        logic [AC_MAX-1:0] ac;       // next AC. Bits at and above ac_w are zero.
        logic              e;        // next E (only meaningful when e_valid)
        logic              e_valid;  // this select produces an E result
    } alu_res_t;

    // Number of asserted select strobes. Legal loads have exactly one.
    function automatic int unsigned sel_count(input sel_t sel);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(SEL_W); i++) begin
            if (sel[i]) n = n + 1;
        end
        return n;
    endfunction

    // Next {E, AC} for a single one-hot select. Any other select value
    // (including SEL_NONE) returns AC unchanged and no E result.
    // Operands must already be zero-extended to AC_MAX bits.
    function automatic alu_res_t alu_eval(
        input logic [AC_MAX-1:0] ac,
        input logic              e,
        input logic [AC_MAX-1:0] dr,
        input logic [AC_MAX-1:0] inpr,
        input sel_t              sel,
        input int unsigned       ac_w,
        input int unsigned       in_w
    );
        alu_res_t          res;
        logic [AC_MAX-1:0] mask;
        logic [AC_MAX-1:0] in_mask;
        logic [AC_MAX-1:0] e_ext;
        logic [AC_MAX-1:0] top_shift;
        logic [AC_MAX:0]   sum;
        logic [AC_MAX:0]   carry_shift;

        mask      = {AC_MAX{1'b1}} >> (AC_MAX - ac_w);
        in_mask   = {AC_MAX{1'b1}} >> (AC_MAX - in_w);
        e_ext     = {{(AC_MAX-1){1'b0}}, e};
        // Bit 0 of top_shift is AC[ac_w-1]. Shifting avoids a variable bit
        // index.
        top_shift = (ac & mask) >> (ac_w - 1);
        // The sum is one bit wider than AC, so the carry is bit ac_w.
        sum         = {1'b0, ac & mask} + {1'b0, dr & mask};
        carry_shift = sum >> ac_w;

        res.ac      = ac & mask;
        res.e       = e;
        res.e_valid = 1'b0;

        case (sel)
            SEL_AND: res.ac = ac & dr & mask;
            SEL_ADD: begin
                res.ac      = sum[AC_MAX-1:0] & mask;
                res.e       = carry_shift[0];
                res.e_valid = 1'b1;
            end
            SEL_DR:  res.ac = dr & mask;
            SEL_SHL: begin
                // Rotate left through E: E goes into bit 0, the old MSB goes into E.
                res.ac      = ((ac << 1) | e_ext) & mask;
                res.e       = top_shift[0];
                res.e_valid = 1'b1;
            end
            SEL_SHR: begin
                // Rotate right through E: E goes into the MSB, the old bit 0 goes into E.
                res.ac      = ((ac & mask) >> 1) | (e_ext << (ac_w - 1));
                res.e       = ac[0];
                res.e_valid = 1'b1;
            end
            SEL_COM:  res.ac = ~ac & mask;
            SEL_INPT: res.ac = (ac & mask & ~in_mask) | (inpr & in_mask);
            default:  res.ac = ac & mask;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/accumulator_unit_ac_alu.sv
// ---------------------------------------------------------------------------
// ac_alu
//   Combinational function unit of the accumulator. It evaluates the selected
//   ALU operation on the current AC/E and does not decide whether the
//   result is used. The caller drives sel = SEL_NONE when no load is
//   executed.
//
// Ports
//   ac      in  AC_W  current accumulator
//   e       in  1     current E flip-flop
//   dr      in  AC_W  data register operand
//   inpr    in  IN_W  input register operand
//   sel     in  7     one-hot select (SEL_* in accumulator_unit_pkg)
//   ac_next out AC_W  AC result
//   e_next  out 1     E result
//   e_valid out 1     select produces an E result (add/shl/shr)
// ---------------------------------------------------------------------------
module ac_alu
    import accumulator_unit_pkg::*;
#(
    parameter int unsigned AC_W = AC_W_DEFAULT,
    parameter int unsigned IN_W = IN_W_DEFAULT
) (
    input  logic [AC_W-1:0] ac,
    input  logic            e,
    input  logic [AC_W-1:0] dr,
    input  logic [IN_W-1:0] inpr,
    input  sel_t            sel,
    output logic [AC_W-1:0] ac_next,
    output logic            e_next,
    output logic            e_valid
);

    alu_res_t res;
    logic     unused_hi;

    always_comb begin
        res = alu_eval(AC_MAX'(ac), e, AC_MAX'(dr), AC_MAX'(inpr), sel, AC_W, IN_W);
    end

    assign ac_next = res.ac[AC_W-1:0];
    assign e_next  = res.e;
    assign e_valid = res.e_valid;

    // alu_eval zeroes everything above AC_W. Those bits are intentionally dropped.
    assign unused_hi = ^res.ac[AC_MAX-1:AC_W];

endmodule

// File: rtl/accumulator_unit.sv
// ---------------------------------------------------------------------------
// accumulator_unit
//   AC register and E flip-flop of the basic computer. The unit executes the
//   strobes from the AC control decoder. It also flags illegal strobe
//   combinations in a sticky err bit.
//
//   AC priority: clr > inr > ld (with exactly one select) > hold.
//   E  priority: executed add/shl/shr result > cle > cme > hold.
//   An illegal combination still follows these priorities. A load with zero
//   selects or with two or more selects is suppressed.
//
// Ports
//   clk, rst_n           rising-edge clock, async active-low reset
//   ld                   load AC from the selected function
//   and_op add_op dr_op  ALU selects (AND, ADD into E, DR)
//   shl shr com inpt     ALU selects (rotate L/R through E, complement, INPR)
//   inr clr              increment / clear AC
//   cle cme              clear / complement E
//   err_clr              clear the sticky err flag (a new error wins)
//   dr [AC_W], inpr [IN_W]  operands
//   ac, e                registered accumulator and E
//   ac_neg ac_zero e_zero   skip-instruction status, decoded from registers
//   err                  sticky illegal-strobe flag
// ---------------------------------------------------------------------------
module accumulator_unit
    import accumulator_unit_pkg::*;
#(
    parameter int unsigned AC_W = AC_W_DEFAULT,
    parameter int unsigned IN_W = IN_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld,
    input  logic            and_op,
    input  logic            add_op,
    input  logic            dr_op,
    input  logic            shl,
    input  logic            shr,
    input  logic            com,
    input  logic            inpt,
    input  logic            inr,
    input  logic            clr,
    input  logic            cle,
    input  logic            cme,
    input  logic            err_clr,
    input  logic [AC_W-1:0] dr,
    input  logic [IN_W-1:0] inpr,
    output logic [AC_W-1:0] ac,
    output logic            e,
    output logic            ac_neg,
    output logic            ac_zero,
    output logic            e_zero,
    output logic            err
);

    logic [AC_W-1:0] ac_q;
    logic            e_q;
    logic            err_q;

    sel_t            sel;
    sel_t            alu_sel;
    logic            sel_one;
    logic            ld_exec;
    logic            alu_e_exec;
    logic            err_event;

    logic [AC_W-1:0] alu_ac;
    logic            alu_e;
    logic            alu_e_valid;

    logic [AC_W-1:0] ac_d;
    logic            e_d;
    logic            err_d;

    // Packed so that each strobe lands on its SEL_* bit.
    assign sel     = {inpt, com, shr, shl, dr_op, add_op, and_op};
    assign sel_one = (sel_count(sel) == 1);

    // A load executes only when it is well formed and no higher-priority AC
    // strobe is present. Otherwise the ALU sees no select, so it cannot leak an
    // E result.
    assign ld_exec = ld & sel_one & ~clr & ~inr;
    assign alu_sel = ld_exec ? sel : SEL_NONE;

    ac_alu #(
        .AC_W (AC_W),
        .IN_W (IN_W)
    ) u_ac_alu (
        .ac      (ac_q),
        .e       (e_q),
        .dr      (dr),
        .inpr    (inpr),
        .sel     (alu_sel),
        .ac_next (alu_ac),
        .e_next  (alu_e),
        .e_valid (alu_e_valid)
    );

    assign alu_e_exec = ld_exec & alu_e_valid;

    assign err_event = (ld & ~sel_one)
                     | (ld & (clr | inr))
                     | (clr & inr)
                     | (alu_e_exec & (cle | cme))
                     | (cle & cme);

    always_comb begin
        ac_d = ac_q;
        if (clr) begin
            ac_d = '0;
        end else if (inr) begin
            ac_d = ac_q + AC_W'(1);
        end else if (ld_exec) begin
            ac_d = alu_ac;
        end
    end

    always_comb begin
        e_d = e_q;
        if (alu_e_exec) begin
            e_d = alu_e;
        end else if (cle) begin
            e_d = 1'b0;
        end else if (cme) begin
            e_d = ~e_q;
        end
    end

    // A new error in the same cycle overrides err_clr.
    always_comb begin
        err_d = err_q;
        if (err_event) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q  <= '0;
            e_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ac_q  <= ac_d;
            e_q   <= e_d;
            err_q <= err_d;
        end
    end

    assign ac      = ac_q;
    assign e       = e_q;
    assign err     = err_q;
    assign ac_neg  = ac_q[AC_W-1];
    assign ac_zero = (ac_q == '0);
    assign e_zero  = ~e_q;

endmodule

// File: tb/tb_accumulator_unit.sv
// ---------------------------------------------------------------------------
// tb_accumulator_unit
//   Self-checking bench for accumulator_unit (AC_W=16, IN_W=8).
//   A table of strobe vectors runs back to back from reset. Each entry
//   carries the AC/E/err state expected one clock later. A scoreboard queue
//   holds {ac, e, err}, and the status flags are derived from it. Reset at
//   start-up and a reset in the middle of a sequence are checked by hand.
// ---------------------------------------------------------------------------
module tb_accumulator_unit;

    localparam int AC_W = 16;
    localparam int IN_W = 8;

    localparam logic [12:0] S_NONE = 13'h0000;
    localparam logic [12:0] S_LD   = 13'h0001;
    localparam logic [12:0] S_AND  = 13'h0002;
    localparam logic [12:0] S_ADD  = 13'h0004;
    localparam logic [12:0] S_DR   = 13'h0008;
    localparam logic [12:0] S_SHL  = 13'h0010;
    localparam logic [12:0] S_SHR  = 13'h0020;
    localparam logic [12:0] S_COM  = 13'h0040;
    localparam logic [12:0] S_INPT = 13'h0080;
    localparam logic [12:0] S_INR  = 13'h0100;
    localparam logic [12:0] S_CLR  = 13'h0200;
    localparam logic [12:0] S_CLE  = 13'h0400;
    localparam logic [12:0] S_CME  = 13'h0800;
    localparam logic [12:0] S_ERRC = 13'h1000;

    typedef struct {
        string           name;
        logic [12:0]     stb;
        logic [AC_W-1:0] dr;
        logic [IN_W-1:0] inpr;
        logic [AC_W-1:0] exp_ac;
        logic            exp_e;
        logic            exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    logic ld, and_op, add_op, dr_op, shl, shr, com, inpt, inr, clr, cle, cme, err_clr;
    logic [AC_W-1:0] dr;
    logic [IN_W-1:0] inpr;
    logic [AC_W-1:0] ac;
    logic e, ac_neg, ac_zero, e_zero, err;

    vec_t vecs[$];
    logic [AC_W+1:0] exp_q[$];   // {ac, e, err}
    int n_cmp;
    int n_bad;

    accumulator_unit #(.AC_W(AC_W), .IN_W(IN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ld),
        .and_op  (and_op),
        .add_op  (add_op),
        .dr_op   (dr_op),
        .shl     (shl),
        .shr     (shr),
        .com     (com),
        .inpt    (inpt),
        .inr     (inr),
        .clr     (clr),
        .cle     (cle),
        .cme     (cme),
        .err_clr (err_clr),
        .dr      (dr),
        .inpr    (inpr),
        .ac      (ac),
        .e       (e),
        .ac_neg  (ac_neg),
        .ac_zero (ac_zero),
        .e_zero  (e_zero),
        .err     (err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [12:0] stb, input logic [AC_W-1:0] d, input logic [IN_W-1:0] ip);
        ld      = stb[0];
        and_op  = stb[1];
        add_op  = stb[2];
        dr_op   = stb[3];
        shl     = stb[4];
        shr     = stb[5];
        com     = stb[6];
        inpt    = stb[7];
        inr     = stb[8];
        clr     = stb[9];
        cle     = stb[10];
        cme     = stb[11];
        err_clr = stb[12];
        dr      = d;
        inpr    = ip;
    endtask

    task automatic add_vec(input string nm, input logic [12:0] stb, input logic [AC_W-1:0] d,
                           input logic [IN_W-1:0] ip, input logic [AC_W-1:0] a,
                           input logic ee, input logic er);
        vec_t v;
        v.name = nm; v.stb = stb; v.dr = d; v.inpr = ip;
        v.exp_ac = a; v.exp_e = ee; v.exp_err = er;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_out(input string nm);
        logic [AC_W+1:0] x;
        logic [AC_W+4:0] exp_full;
        logic [AC_W+4:0] act_full;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, no expected value", nm);
        end else begin
            x = exp_q.pop_front();
            exp_full = {x, x[AC_W+1], (x[AC_W+1:2] == '0), ~x[1]};
            act_full = {ac, e, err, ac_neg, ac_zero, e_zero};
            if (act_full !== exp_full) begin
                n_bad++;
                $display("FAIL %s: got ac=%h e=%b err=%b neg=%b zero=%b ez=%b, want ac=%h e=%b err=%b neg=%b zero=%b ez=%b",
                         nm, ac, e, err, ac_neg, ac_zero, e_zero,
                         exp_full[AC_W+4:5], exp_full[4], exp_full[3], exp_full[2], exp_full[1], exp_full[0]);
            end
        end
    endtask

    task automatic run_step(input logic [12:0] stb, input logic [AC_W-1:0] d, input logic [IN_W-1:0] ip,
                            input logic [AC_W-1:0] a, input logic ee, input logic er, input string nm);
        @(negedge clk);
        apply(stb, d, ip);
        exp_q.push_back({a, ee, er});
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    // ---------------- test ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        apply(S_NONE, '0, '0);
        rst_n = 1'b0;

        // Reset state is visible before the first clock edge.
        #2;
        exp_q.push_back({16'h0000, 1'b0, 1'b0});
        check_out("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Test vectors. Each entry operates on the state left by the one before.
        add_vec("pre_ffff",    S_LD|S_DR,            16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0);
        add_vec("add_carry",   S_LD|S_ADD,           16'h0001, 8'h00, 16'h0000, 1'b1, 1'b0);
        add_vec("pre_1234",    S_LD|S_DR,            16'h1234, 8'h00, 16'h1234, 1'b1, 1'b0);
        add_vec("and",         S_LD|S_AND,           16'h00F0, 8'h00, 16'h0030, 1'b1, 1'b0);
        add_vec("cle",         S_CLE,                16'h0000, 8'h00, 16'h0030, 1'b0, 1'b0);
        add_vec("pre_8001",    S_LD|S_DR,            16'h8001, 8'h00, 16'h8001, 1'b0, 1'b0);
        add_vec("shl",         S_LD|S_SHL,           16'h0000, 8'h00, 16'h0002, 1'b1, 1'b0);
        add_vec("shr",         S_LD|S_SHR,           16'h0000, 8'h00, 16'h8001, 1'b0, 1'b0);
        add_vec("shl_a",       S_LD|S_SHL,           16'h0000, 8'h00, 16'h0002, 1'b1, 1'b0);
        add_vec("shl_b",       S_LD|S_SHL,           16'h0000, 8'h00, 16'h0005, 1'b0, 1'b0);
        add_vec("pre_abcd",    S_LD|S_DR,            16'hABCD, 8'h00, 16'hABCD, 1'b0, 1'b0);
        add_vec("inpt",        S_LD|S_INPT,          16'h0000, 8'h5A, 16'hAB5A, 1'b0, 1'b0);
        add_vec("com",         S_LD|S_COM,           16'h0000, 8'h00, 16'h54A5, 1'b0, 1'b0);
        add_vec("sel_no_ld",   S_ADD|S_DR|S_COM,     16'hFFFF, 8'h00, 16'h54A5, 1'b0, 1'b0);
        add_vec("cme",         S_CME,                16'h0000, 8'h00, 16'h54A5, 1'b1, 1'b0);
        add_vec("cme_b",       S_CME,                16'h0000, 8'h00, 16'h54A5, 1'b0, 1'b0);
        add_vec("inr",         S_INR,                16'h0000, 8'h00, 16'h54A6, 1'b0, 1'b0);
        add_vec("prio_all",    S_CLR|S_INR|S_LD|S_DR,16'h1111, 8'h00, 16'h0000, 1'b0, 1'b1);
        add_vec("err_clr_a",   S_ERRC,               16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0);
        add_vec("pre_ffff_b",  S_LD|S_DR,            16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0);
        add_vec("cme_set",     S_CME,                16'h0000, 8'h00, 16'hFFFF, 1'b1, 1'b0);
        add_vec("inr_wrap",    S_INR,                16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0);
        add_vec("pre_8000",    S_LD|S_DR,            16'h8000, 8'h00, 16'h8000, 1'b1, 1'b0);
        add_vec("add_cle",     S_LD|S_ADD|S_CLE,     16'h8000, 8'h00, 16'h0000, 1'b1, 1'b1);
        add_vec("err_clr_b",   S_ERRC,               16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0);
        add_vec("cle_cme",     S_CLE|S_CME,          16'h0000, 8'h00, 16'h0000, 1'b0, 1'b1);
        add_vec("err_clr_c",   S_ERRC,               16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0);
        add_vec("pre_1234_b",  S_LD|S_DR,            16'h1234, 8'h00, 16'h1234, 1'b0, 1'b0);
        add_vec("two_sel",     S_LD|S_ADD|S_DR,      16'h5555, 8'h00, 16'h1234, 1'b0, 1'b1);
        add_vec("clr_vs_err",  S_ERRC|S_LD,          16'h0000, 8'h00, 16'h1234, 1'b0, 1'b1);
        add_vec("err_clr_d",   S_ERRC,               16'h0000, 8'h00, 16'h1234, 1'b0, 1'b0);
        add_vec("ld_no_sel",   S_LD,                 16'hFFFF, 8'h00, 16'h1234, 1'b0, 1'b1);
        add_vec("err_clr_e",   S_ERRC,               16'h0000, 8'h00, 16'h1234, 1'b0, 1'b0);
        add_vec("cme_c",       S_CME,                16'h0000, 8'h00, 16'h1234, 1'b1, 1'b0);
        add_vec("clr_only",    S_CLR,                16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0);
        add_vec("pre_00ff",    S_LD|S_DR,            16'h00FF, 8'h00, 16'h00FF, 1'b1, 1'b0);
        add_vec("shr_clr",     S_LD|S_SHR|S_CLR,     16'h0000, 8'h00, 16'h0000, 1'b1, 1'b1);
        add_vec("err_clr_f",   S_ERRC,               16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0);
        add_vec("add_cme",     S_LD|S_ADD|S_CME,     16'h0001, 8'h00, 16'h0001, 1'b0, 1'b1);
        add_vec("err_clr_g",   S_ERRC,               16'h0000, 8'h00, 16'h0001, 1'b0, 1'b0);
        add_vec("clr_inr",     S_CLR|S_INR,          16'h0000, 8'h00, 16'h0000, 1'b0, 1'b1);
        add_vec("err_clr_h",   S_ERRC,               16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0);
        add_vec("inr_ld",      S_INR|S_LD|S_DR,      16'h7777, 8'h00, 16'h0001, 1'b0, 1'b1);
        add_vec("err_clr_i",   S_ERRC,               16'h0000, 8'h00, 16'h0001, 1'b0, 1'b0);
        add_vec("add_neg",     S_LD|S_ADD,           16'h7FFF, 8'h00, 16'h8000, 1'b0, 1'b0);
        add_vec("shl_msb",     S_LD|S_SHL,           16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            run_step(vecs[i].stb, vecs[i].dr, vecs[i].inpr,
                     vecs[i].exp_ac, vecs[i].exp_e, vecs[i].exp_err, vecs[i].name);
        end

        // Reset in the middle of a sequence. First build up nonzero AC, E and
        // err. Then assert reset between clock edges, with a load pending in
        // the same cycle.
        run_step(S_LD|S_DR, 16'h9999, 8'h00, 16'h9999, 1'b1, 1'b0, "mid_pre");
        run_step(S_LD,      16'h0000, 8'h00, 16'h9999, 1'b1, 1'b1, "mid_err");
        @(negedge clk);
        apply(S_LD|S_DR|S_CME, 16'h1234, 8'h00);
        rst_n = 1'b0;
        #2;
        exp_q.push_back({16'h0000, 1'b0, 1'b0});
        check_out("mid_reset_async");
        @(posedge clk);
        #1;
        exp_q.push_back({16'h0000, 1'b0, 1'b0});
        check_out("mid_reset_held");
        @(negedge clk);
        apply(S_NONE, '0, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({16'h0000, 1'b0, 1'b0});
        check_out("mid_reset_release");

        // Random DR loads followed by COM. The expected value is the bitwise
        // complement of the loaded word.
        for (int k = 0; k < 8; k++) begin
            logic [AC_W-1:0] r;
            r = AC_W'($urandom_range(0, 16'hFFFF));
            run_step(S_LD|S_DR,  r,        8'h00, r,  1'b0, 1'b0, "rnd_load");
            run_step(S_LD|S_COM, 16'h0000, 8'h00, ~r, 1'b0, 1'b0, "rnd_com");
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
